// File: rtl/pattern_encoder_pkg.sv
// Shared types for the pattern encoder: frame FSM states and default width.
package pattern_encoder_pkg;

    localparam int N_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_encoder_piso.sv
// Parallel-load, MSB-first shift-out register used by the pattern encoder.
module piso_shift
    import pattern_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] d,
    output logic         q_msb
);

    logic [N-1:0] shreg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            shreg <= {shreg[N-2:0], 1'b0};
        end
    end

    assign q_msb = shreg[N-1];

endmodule

// File: rtl/pattern_encoder.sv
// Serialises an N-bit pattern MSB-first onto the signal or program stream.
module pattern_encoder
    import pattern_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         mode,
    input  logic         abort,
    input  logic [N-1:0] pattern,
    output logic         sig,
    output logic         prgm,
    output logic         prgm_en,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          mode_q;
    logic          load;
    logic          shift;
    logic          last;
    logic          msb;
    logic          sending;

    assign last = (cnt == CW'(N - 1));

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                shift = 1'b1;
                if (abort) begin
                    state_n = IDLE;
                end else if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                cnt    <= '0;
                mode_q <= mode;
            end else if (shift) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    piso_shift #(
        .N(N)
    ) u_piso (
        .clk  (clk),
        .clr  (clr),
        .load (load),
        .shift(shift),
        .d    (pattern),
        .q_msb(msb)
    );

    // Outputs decode flops only, so they are glitch-free and input-independent.
    assign sending = (state == SEND);
    assign sig     = sending && !mode_q && msb;
    assign prgm    = sending && mode_q && msb;
    assign prgm_en = sending && mode_q;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_pattern_encoder.sv
// Bench for pattern_encoder: N=8 cycle model plus an N=1024 loopback chain.
module tb_pattern_encoder;

    logic clk = 1'b0;
    logic clr;

    logic       start;
    logic       mode;
    logic       abort;
    logic [7:0] pattern;
    logic       sig;
    logic       prgm;
    logic       prgm_en;
    logic       busy;
    logic       done;

    logic          start1;
    logic          mode1;
    logic          abort1;
    logic [1023:0] pattern1;
    logic          sig1;
    logic          prgm1;
    logic          prgm_en1;
    logic          busy1;
    logic          done1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state for the N=8 instance.
    bit         m_act;
    int         m_pos;
    logic [7:0] m_pat;
    logic       m_mode;

    always #5 clk = ~clk;

    pattern_encoder #(.N(8)) u8 (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .mode   (mode),
        .abort  (abort),
        .pattern(pattern),
        .sig    (sig),
        .prgm   (prgm),
        .prgm_en(prgm_en),
        .busy   (busy),
        .done   (done)
    );

    pattern_encoder #(.N(1024)) u1k (
        .clk    (clk),
        .clr    (clr),
        .start  (start1),
        .mode   (mode1),
        .abort  (abort1),
        .pattern(pattern1),
        .sig    (sig1),
        .prgm   (prgm1),
        .prgm_en(prgm_en1),
        .busy   (busy1),
        .done   (done1)
    );

    task automatic chk(input string tag, input logic [1023:0] obs,
                       input logic [1023:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {sig,prgm,prgm_en,busy,done} from frame position.
    function automatic logic [4:0] m_exp();
        logic b;
        if (!m_act) return 5'b0;
        if (m_pos == 8) return 5'b00011;
        b = m_pat[7 - m_pos];
        return {!m_mode && b, m_mode && b, m_mode, 1'b1, 1'b0};
    endfunction

    task automatic tick(input string tag, input logic s, input logic md,
                        input logic a, input logic [7:0] p);
        start   = s;
        mode    = md;
        abort   = a;
        pattern = p;
        @(posedge clk);
        if (m_act) begin
            if (a || m_pos == 8) m_act = 0;
            else m_pos++;
        end else if (s && !a) begin
            m_act  = 1;
            m_pos  = 0;
            m_pat  = p;
            m_mode = md;
        end
        @(negedge clk);
        chk(tag, 1024'({sig, prgm, prgm_en, busy, done}), 1024'(m_exp()));
    endtask

    task automatic idle_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick(tag, 1'b0, 1'($urandom), 1'b0, 8'($urandom));
        end
    endtask

    // Downstream shift-in chain on the selected stream of the 1024-bit unit.
    task automatic loopback(input logic md, input logic [1023:0] p,
                            output logic [1023:0] rx, output int dcyc,
                            output int errs);
        start1   = 1'b1;
        mode1    = md;
        pattern1 = p;
        @(posedge clk);
        @(negedge clk);
        start1   = 1'b0;
        mode1    = ~md;
        pattern1 = ~p;
        rx   = '0;
        dcyc = 0;
        errs = 0;
        for (int c = 1; c <= 1026; c++) begin
            if (c <= 1024) rx = {rx[1022:0], (md ? prgm1 : sig1)};
            if (done1 && dcyc == 0) dcyc = c;
            if (prgm_en1 !== (md && c <= 1024)) errs++;
            if ((md ? sig1 : (prgm1 | prgm_en1)) !== 1'b0) errs++;
            if (busy1 !== (c <= 1025)) errs++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [1023:0] p;
        logic [1023:0] rx;
        int            dcyc;
        int            errs;

        clr      = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        abort    = 1'b0;
        pattern  = '0;
        start1   = 1'b0;
        mode1    = 1'b0;
        abort1   = 1'b0;
        pattern1 = '0;
        m_act    = 0;
        m_pos    = 0;
        m_pat    = '0;
        m_mode   = 0;

        #2;
        chk("reset_state", 1024'({sig, prgm, prgm_en, busy, done}), 1024'(0));
        chk("reset_state1k", 1024'({sig1, prgm1, prgm_en1, busy1, done1}),
            1024'(0));
        @(negedge clk);
        clr = 1'b1;
        idle_ticks("idle", 2);

        tick("sig_a5", 1'b1, 1'b0, 1'b0, 8'hA5);
        idle_ticks("sig_a5", 11);

        tick("prgm_3c", 1'b1, 1'b1, 1'b0, 8'h3C);
        idle_ticks("prgm_3c", 11);

        tick("abort_mid", 1'b1, 1'b0, 1'b0, 8'hFF);
        idle_ticks("abort_mid", 3);
        tick("abort_mid", 1'b1, 1'b0, 1'b1, 8'h00);
        tick("abort_restart", 1'b1, 1'b1, 1'b0, 8'h96);
        idle_ticks("abort_restart", 11);

        tick("abort_idle", 1'b1, 1'b0, 1'b1, 8'h81);
        idle_ticks("abort_idle", 2);

        for (int i = 0; i < 30; i++) begin
            tick("start_held", 1'b1, 1'b0, 1'b0, 8'hFF);
        end
        idle_ticks("start_held", 4);

        tick("clr_mid", 1'b1, 1'b1, 1'b0, 8'hE7);
        idle_ticks("clr_mid", 3);
        #1 clr = 1'b0;
        #1;
        chk("clr_async", 1024'({sig, prgm, prgm_en, busy, done}), 1024'(0));
        m_act = 0;
        #1 clr = 1'b1;
        idle_ticks("clr_after", 10);
        tick("clr_restart", 1'b1, 1'b0, 1'b0, 8'h5A);
        idle_ticks("clr_restart", 11);

        for (int i = 0; i < 400; i++) begin
            tick("random", 1'($urandom_range(3) == 0), 1'($urandom),
                 1'($urandom_range(19) == 0), 8'($urandom));
        end
        idle_ticks("random_tail", 10);

        for (int i = 0; i < 32; i++) p[i*32 +: 32] = $urandom;

        loopback(1'b1, p, rx, dcyc, errs);
        chk("lb_prgm_data", rx, p);
        chk("lb_prgm_done", 1024'(dcyc), 1024'(1025));
        chk("lb_prgm_ctrl", 1024'(errs), 1024'(0));

        loopback(1'b0, p, rx, dcyc, errs);
        chk("lb_sig_match", 1024'(rx == p), 1024'(1));
        chk("lb_sig_done", 1024'(dcyc), 1024'(1025));
        chk("lb_sig_ctrl", 1024'(errs), 1024'(0));

        loopback(1'b0, p ^ 1024'(1), rx, dcyc, errs);
        chk("lb_nomatch", 1024'(rx == p), 1024'(0));
        chk("lb_nomatch_data", rx, p ^ 1024'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_encoder.md
PATTERN_ENCODER -- requirements
Module: pattern_encoder

Interface
REQ-001 Parameter N, default 1024, pattern width in bits (N >= 2).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 clr  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to transmit pattern; sampled on clk rising edge.
REQ-005 mode  input  1  0 = signal frame on sig, 1 = program frame on prgm; sampled with start.
REQ-006 abort  input  1  synchronous cancel of an active frame.
REQ-007 pattern  input  N  parallel pattern to serialise; sampled with start.
REQ-008 sig  output  1  serial signal stream, registered.
REQ-009 prgm  output  1  serial program stream, registered.
REQ-010 prgm_en  output  1  program-register shift enable, registered.
REQ-011 busy  output  1  high while a frame is in progress; start is ignored while high.
REQ-012 done  output  1  one-cycle pulse after the last bit of a completed frame.

Function
REQ-013 FSM states: IDLE, SEND, DONE.
REQ-014 IDLE with start=1 at edge k: latch pattern into the shift register, latch mode, clear the bit counter, enter SEND.
REQ-015 In SEND, drive shreg[N-1] on the selected stream each cycle, shift left by one, and increment the counter.
REQ-016 Bit order: pattern[N-1] first and pattern[0] last, so that a downstream shift-in chain holds bit i at position i after N shifts.
REQ-017 Latency: the first bit is valid in cycle k+1, the last bit in cycle k+N, and done=1 in cycle k+N+1 only.
REQ-018 SEND exits to DONE when the counter equals N-1, with the last bit driven in that cycle.
REQ-019 DONE lasts exactly one cycle, then the FSM returns to IDLE; start is accepted again in the first IDLE cycle (back-to-back frame gap = 1 cycle).
REQ-020 mode=0: sig carries the data, while prgm=0 and prgm_en=0 throughout.
REQ-021 mode=1: prgm carries the data and prgm_en=1 for exactly the N SEND cycles, while sig=0.
REQ-022 Outside SEND: sig=0, prgm=0, prgm_en=0.
REQ-023 busy=1 in SEND and DONE, and 0 in IDLE.
REQ-024 start asserted while busy=1 has no effect; pattern and mode changes during a frame do not alter the frame.
REQ-025 abort=1 in SEND or DONE: next cycle IDLE, all outputs 0, no done pulse; abort has priority over start in the same cycle.
REQ-026 abort in IDLE: no effect, and start in the same cycle is not accepted.
REQ-027 Counter width: $clog2(N) bits; it does not wrap within a frame.

Reset
REQ-028 clr=0 forces IDLE immediately, independent of clk: sig=prgm=prgm_en=busy=done=0, counter=0, shift register=0.
REQ-029 clr=0 asserted mid-frame discards the frame without a done pulse; after release, the first rising edge with start=1 begins a new frame normally.

Structure
REQ-030 A shared package holds the state enum (IDLE, SEND, DONE) and the default N constant.
REQ-031 The parallel-load/shift-out register is one sub-module, piso_shift, with ports clk, clr, load, shift, d[N-1:0], and q_msb.
REQ-032 The FSM, counter and output steering live in pattern_encoder.

Verification
REQ-033 N=8, mode=0, pattern=8'hA5, start at edge k -> sig=1,0,1,0,0,1,0,1 in cycles k+1..k+8; done=1 in k+9 only; prgm=prgm_en=0.
REQ-034 N=8, mode=1, pattern=8'h3C -> prgm=0,0,1,1,1,1,0,0 with prgm_en=1 in cycles k+1..k+8; sig=0.
REQ-035 N=8 frame, abort at cycle k+4 -> cycle k+5 busy=0 and all outputs 0; no done pulse; a new start in k+5 is accepted.
REQ-036 start held high continuously, pattern=8'hFF -> frames start at k, k+10, k+20; intermediate start pulses are ignored.
REQ-037 clr pulsed low mid-frame between clock edges -> outputs 0 before the next edge; no done pulse.
REQ-038 N=1024 loopback: a program frame of pattern P, then a signal frame of P into the 1024-bit pattern decoder -> the decoder match output=1 in the cycle after encoder done; a signal frame of P^1 -> match=0.
